// File: rtl/itlc_dec_pkg.sv
// Shared types and helpers for the one-hot scan decoder.
// The FSM state encoding and the one-hot helper live here.
package itlc_dec_pkg;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN_ON, SCAN_BLANK} dec_state_t;

  localparam int MAX_BLANK = 15;
  // Widest decode the helper can produce (SEL_W up to 8).
  localparam int MAX_OUT_W = 256;

  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx,
                                                  input int unsigned width);
    onehot = '0;
    if (idx < width && idx < MAX_OUT_W) onehot[idx[7:0]] = 1'b1;
  endfunction

endpackage

// File: rtl/dec_slot_timer.sv
// Loadable down-counter used for both the dwell and the blanking intervals.
// done is high whenever the count has reached zero.
module dec_slot_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a direct-select mode and an
// autonomous scan mode (programmable dwell, optional blanking between lines).
module onehot_scan_decoder
  import itlc_dec_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int OUT_W      = 2**SEL_W,
  parameter int DWELL_W    = 8,
  parameter int BLANK      = 0,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   f,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap,
  output logic               sel_err
);

  localparam int CNT_W     = (DWELL_W > 4) ? DWELL_W : 4;
  localparam int BLANK_EFF = (BLANK > MAX_BLANK) ? MAX_BLANK : BLANK;
  localparam logic POL     = (ACTIVE_LOW != 0);
  localparam logic [OUT_W-1:0] INACTIVE   = {OUT_W{POL}};
  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(OUT_W - 1);
  localparam logic [SEL_W:0]   OUT_W_L    = (SEL_W + 1)'(OUT_W);
  localparam logic [CNT_W-1:0] BLANK_LOAD = (BLANK_EFF > 0) ? CNT_W'(BLANK_EFF - 1) : '0;

  dec_state_t       state, state_nxt;
  logic [OUT_W-1:0] line_nxt;
  logic [SEL_W-1:0] idx_nxt, idx_adv;
  logic             show, wrap_nxt, err_nxt;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;

  dec_slot_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    show      = 1'b0;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    tmr_load  = 1'b1;
    tmr_val   = '0;
    line_nxt  = '0;
    idx_adv   = (idx == LAST_IDX) ? '0 : idx + 1'b1;

    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else if (!mode) begin
      state_nxt = DIRECT;
      if ({1'b0, sel} >= OUT_W_L) begin
        err_nxt = 1'b1;
      end else begin
        idx_nxt = sel;
        show    = 1'b1;
      end
    end else begin
      case (state)
        IDLE, DIRECT: begin
          state_nxt = SCAN_ON;
          idx_nxt   = '0;
          show      = 1'b1;
          tmr_val   = CNT_W'(dwell);
        end
        SCAN_ON: begin
          if (!tmr_done) begin
            tmr_load = 1'b0;
            show     = 1'b1;
          end else if (BLANK_EFF > 0) begin
            state_nxt = SCAN_BLANK;
            tmr_val   = BLANK_LOAD;
          end else begin
            idx_nxt  = idx_adv;
            wrap_nxt = (idx == LAST_IDX);
            show     = 1'b1;
            tmr_val  = CNT_W'(dwell);
          end
        end
        SCAN_BLANK: begin
          if (!tmr_done) begin
            tmr_load = 1'b0;
          end else begin
            state_nxt = SCAN_ON;
            idx_nxt   = idx_adv;
            wrap_nxt  = (idx == LAST_IDX);
            show      = 1'b1;
            tmr_val   = CNT_W'(dwell);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (show) line_nxt = OUT_W'(onehot(32'(idx_nxt), OUT_W));
  end

  // Polarity is applied right at the register so f stays a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      f       <= INACTIVE;
      idx     <= '0;
      wrap    <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      f       <= line_nxt ^ INACTIVE;
      idx     <= idx_nxt;
      wrap    <= wrap_nxt;
      sel_err <= err_nxt;
    end
  end

endmodule
